// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3/mem_size encodings, FSM state type and
// request-classification helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // funct3 011/11x are never legal; stores have no unsigned variants
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  // sz is funct3[1:0]; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == MEM_HALF) && a[0]) || ((sz == MEM_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of raw load data according to RV32
// load funct3. Used for both single-access and byte-assembled loads.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_ext
);

  // extend from bit 7/15 for signed loads, clear upper bits for unsigned
  always_comb begin
    o_ext = i_raw;
    case (i_funct3)
      F3_B:    o_ext = {{(XLEN-8){i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_ext = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
      F3_BU:   o_ext = {{(XLEN-8){1'b0}}, i_raw[7:0]};
      F3_HU:   o_ext = {{(XLEN-16){1'b0}}, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: execute-stage to data-memory initiator. One request per
// handshake, IDLE -> ACCESS -> RESP. Misaligned half/word accesses are
// split into byte accesses when LSU_MISALIGN_SPLIT_EN is defined and
// fault otherwise. All outputs are held at 0 while rst_n is low.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_write,
  output logic              mem_read,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [XLEN-1:0]   r_resp_rdata;

  logic              w_req_mis;
  logic              w_req_fault;
  logic              w_acc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [XLEN-1:0]   w_wdata_al;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ext_raw;
  logic [XLEN-1:0]   w_ext;

  assign w_req_mis = is_misaligned(req_funct3[1:0], req_addr[1:0]);

  // store data masked to the access size for a single aligned access
  always_comb begin
    case (r_f3[1:0])
      MEM_BYTE: w_wdata_al = {{(XLEN-8){1'b0}}, r_wdata[7:0]};
      MEM_HALF: w_wdata_al = {{(XLEN-16){1'b0}}, r_wdata[15:0]};
      default:  w_wdata_al = r_wdata;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic            r_split;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_asm;
  logic [XLEN-1:0] w_asm_next;

  assign w_req_fault = f3_illegal(req_we, req_funct3);
  assign w_last      = !r_split || (r_cnt == ((r_f3[1:0] == MEM_HALF) ? 2'd1 : 2'd3));
  assign w_addr      = r_split ? (r_addr + ADDR_W'(r_cnt)) : r_addr;
  assign w_size      = r_split ? MEM_BYTE : r_f3[1:0];

  // assembly value including the byte being read this cycle, so the last
  // byte can be extended without an extra cycle
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_cnt, 3'b000} +: 8] = mem_rdata[7:0];
  end

  assign w_ext_raw = r_split ? w_asm_next : mem_rdata;

  // split stores present one right-aligned byte per access
  always_comb begin
    w_wdata = w_wdata_al;
    if (r_split) begin
      w_wdata      = '0;
      w_wdata[7:0] = r_wdata[{r_cnt, 3'b000} +: 8];
    end
  end
`else
  assign w_req_fault = f3_illegal(req_we, req_funct3) || w_req_mis;
  assign w_last      = 1'b1;
  assign w_addr      = r_addr;
  assign w_size      = r_f3[1:0];
  assign w_ext_raw   = mem_rdata;
  assign w_wdata     = w_wdata_al;
`endif

  lsu_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .i_funct3(r_f3),
    .i_raw   (w_ext_raw),
    .o_ext   (w_ext)
  );

  // memory port is live only in ACCESS; gating with rst_n stops a write
  // from committing on the edge where reset is taken
  assign w_acc     = (r_state == ACCESS) && rst_n;
  assign mem_write = w_acc && r_we;
  assign mem_read  = w_acc && !r_we;
  assign mem_size  = w_acc ? w_size : '0;
  assign mem_addr  = w_acc ? w_addr : '0;
  assign mem_wdata = (w_acc && r_we) ? w_wdata : '0;

  assign req_ready  = (r_state == IDLE) && rst_n;
  assign resp_valid = r_resp_valid && rst_n;
  assign resp_fault = r_resp_fault && rst_n;
  assign resp_rdata = rst_n ? r_resp_rdata : '0;

  // request FSM: capture, access (one or N byte cycles), one-cycle response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split      <= 1'b0;
      r_cnt        <= '0;
      r_asm        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split <= w_req_mis;
            r_cnt   <= '0;
            r_asm   <= '0;
`endif
            if (w_req_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!w_last) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cnt <= r_cnt + 2'd1;
            r_asm <= w_asm_next;
`endif
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= r_we ? '0 : w_ext;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized traffic checked
// against a byte-array reference of memory and the RV32 load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  longint t_resp = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 256-byte data memory, aliased on the low address byte
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_read) begin
      case (mem_size)
        2'b00:   mem_rdata = {24'h0, mem[ma]};
        2'b01:   mem_rdata = {16'h0, mem[ma + 8'd1], mem[ma]};
        default: mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_size)
        2'b00: mem[ma] <= mem_wdata[7:0];
        2'b01: begin mem[ma] <= mem_wdata[7:0]; mem[ma + 8'd1] <= mem_wdata[15:8]; end
        default: begin
          mem[ma] <= mem_wdata[7:0];          mem[ma + 8'd1] <= mem_wdata[15:8];
          mem[ma + 8'd2] <= mem_wdata[23:16]; mem[ma + 8'd3] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;

  acc_t acc_q[$];
  int   both_rw = 0;

  always @(negedge clk) begin
    if (mem_read || mem_write) acc_q.push_back('{we: mem_write, sz: mem_size, a: mem_addr, d: mem_wdata});
    if (mem_read && mem_write) both_rw++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit f3_bad(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic int unsigned ref_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % ref_bytes(f3)) != 0;
  endfunction

  function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3_bad(we, f3)) return 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    return 1'b0;
`else
    return ref_mis(f3, a);
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int unsigned n;
    v = '0;
    n = ref_bytes(f3);
    for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[8'(a + i)]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int unsigned i = 0; i < ref_bytes(f3); i++) ref_mem[8'(a + i)] = d[8 * i +: 8];
  endtask

  // drive one request, return the response and its latency (-1 on timeout)
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic flt, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    acc_q.delete();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 'x; flt = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; rd = resp_rdata; flt = resp_fault; t_resp = $time; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    n_checks++; if ({resp_valid, resp_fault, resp_rdata} !== 34'h0) begin n_fail++;
      $display("FAIL reset_resp: got %b/%b/%h expected all 0", resp_valid, resp_fault, resp_rdata); end
    n_checks++; if ({mem_read, mem_write, mem_size, mem_addr, mem_wdata} !== 68'h0) begin n_fail++;
      $display("FAIL reset_mem: got rd=%b wr=%b sz=%b a=%h d=%h expected all 0", mem_read, mem_write, mem_size, mem_addr, mem_wdata); end
    rst_n = 1'b1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic flt; int lat;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, lat);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    n_checks++; if (lat !== 2 || flt !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got lat=%0d fault=%b expected lat=2 fault=0", lat, flt); end
    n_checks++; if ((acc_q.size() > 0 ? acc_q[0] : '0) !== {1'b1, 2'b10, 32'h10, 32'hDEADBEEF} || acc_q.size() != 1) begin n_fail++;
      $display("FAIL sw_access: got n=%0d first=%h expected one write sz=10 a=10 d=deadbeef", acc_q.size(), acc_q.size() > 0 ? acc_q[0] : '0); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'hDEADBEEF || lat !== 2) begin n_fail++; $display("FAIL lw_readback: got %h lat=%0d expected deadbeef lat=2", rd, lat); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic flt; int lat;
    issue(1'b1, 3'b000, 32'h21, 32'h12345680, rd, flt, lat); ref_store(3'b000, 32'h21, 32'h12345680);
    issue(1'b0, 3'b000, 32'h21, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h expected ffffff80", rd); end
    issue(1'b0, 3'b100, 32'h21, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h expected 00000080", rd); end
    issue(1'b1, 3'b001, 32'h30, 32'hABCD8001, rd, flt, lat); ref_store(3'b001, 32'h30, 32'hABCD8001);
    n_checks++; if ((acc_q.size() > 0 ? acc_q[0].d : 32'hX) !== 32'h00008001) begin n_fail++; $display("FAIL sh_wdata_mask: got %h expected 00008001", acc_q.size() > 0 ? acc_q[0].d : 32'h0); end
    issue(1'b0, 3'b001, 32'h30, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h expected ffff8001", rd); end
    issue(1'b0, 3'b101, 32'h30, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h expected 00008001", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic flt; int lat;
    mem[8'h13] = 8'h11; mem[8'h14] = 8'h22; mem[8'h15] = 8'h33; mem[8'h16] = 8'h44;
    ref_mem[8'h13] = 8'h11; ref_mem[8'h14] = 8'h22; ref_mem[8'h15] = 8'h33; ref_mem[8'h16] = 8'h44;
    issue(1'b0, 3'b010, 32'h13, 32'h0, rd, flt, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_checks++; if (rd !== 32'h44332211 || flt !== 1'b0 || lat !== 5) begin n_fail++;
      $display("FAIL lw_split: got %h fault=%b lat=%0d expected 44332211 0 5", rd, flt, lat); end
    n_checks++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL lw_split_count: got %0d expected 4", acc_q.size()); end
    else for (int unsigned i = 0; i < 4; i++) begin
      n_checks++; if (acc_q[i] !== {1'b0, 2'b00, 32'h13 + i, 32'h0}) begin n_fail++;
        $display("FAIL lw_split_access%0d: got %h expected read byte at %h", i, acc_q[i], 32'h13 + i); end
    end
`else
    n_checks++; if (rd !== 32'h0 || flt !== 1'b1 || lat !== 1) begin n_fail++;
      $display("FAIL lw_misaligned_fault: got %h fault=%b lat=%0d expected 0 1 1", rd, flt, lat); end
    n_checks++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL lw_misaligned_noaccess: got %0d accesses expected 0", acc_q.size()); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic flt; int lat;
    issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, rd, flt, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    ref_store(3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    n_checks++; if (acc_q.size() != 4 || lat !== 5) begin n_fail++; $display("FAIL sw_wrap_count: got n=%0d lat=%0d expected 4 5", acc_q.size(), lat); end
    else for (int unsigned i = 0; i < 4; i++) begin
      logic [31:0] d; d = 32'hA1B2C3D4;
      n_checks++; if (acc_q[i] !== {1'b1, 2'b00, 32'hFFFFFFFE + i, 24'h0, d[8 * i +: 8]}) begin n_fail++;
        $display("FAIL sw_wrap_access%0d: got %h expected a=%h", i, acc_q[i], 32'hFFFFFFFE + i); end
    end
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd, flt, lat);
    n_checks++; if (rd !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL lw_wrap: got %h expected a1b2c3d4", rd); end
`else
    n_checks++; if (flt !== 1'b1 || acc_q.size() != 0) begin n_fail++; $display("FAIL sw_wrap_fault: got fault=%b n=%0d expected 1 0", flt, acc_q.size()); end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic flt; int lat;
    issue(1'b0, 3'b011, 32'h40, 32'h0, rd, flt, lat);
    n_checks++; if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1 || acc_q.size() != 0) begin n_fail++;
      $display("FAIL ld_f3_011: got fault=%b rd=%h lat=%0d n=%0d expected 1 0 1 0", flt, rd, lat, acc_q.size()); end
    issue(1'b1, 3'b100, 32'h40, 32'h55, rd, flt, lat);
    n_checks++; if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1 || acc_q.size() != 0) begin n_fail++;
      $display("FAIL st_f3_100: got fault=%b rd=%h lat=%0d n=%0d expected 1 0 1 0", flt, rd, lat, acc_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt; int lat;
    longint t0;
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat);
    t0 = t_resp;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_resp: got %b expected 0", req_ready); end
    issue(1'b0, 3'b000, 32'h21, 32'h0, rd, flt, lat);
    n_checks++; if (t_resp - t0 != 30) begin n_fail++; $display("FAIL throughput: got %0d time units between responses expected 30", t_resp - t0); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic [2:0] f3; logic we, flt, exp_f; int lat, exp_lat;
    int unsigned n, exp_na; bit split, allow_bad;
    acc_t e;
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom);
      allow_bad = ($urandom_range(0, 9) == 0);
      do f3 = 3'($urandom_range(0, 7)); while (!allow_bad && f3_bad(we, f3));
      a = {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h000000, 8'($urandom_range(0, 255))};
      d = $urandom;
      exp_f = ref_fault(we, f3, a);
      n = ref_bytes(f3);
`ifdef LSU_MISALIGN_SPLIT_EN
      split = !exp_f && ref_mis(f3, a);
`else
      split = 1'b0;
`endif
      exp_lat = exp_f ? 1 : (split ? 1 + int'(n) : 2);
      exp_rd  = (exp_f || we) ? 32'h0 : ref_load(f3, a);
      exp_na  = exp_f ? 0 : (split ? n : 1);
      issue(we, f3, a, d, rd, flt, lat);
      n_checks++; if (flt !== exp_f || lat !== exp_lat || rd !== exp_rd) begin n_fail++;
        $display("FAIL rand%0d_resp we=%b f3=%b a=%h: got fault=%b lat=%0d rd=%h expected %b %0d %h", t, we, f3, a, flt, lat, rd, exp_f, exp_lat, exp_rd); end
      n_checks++; if (acc_q.size() != exp_na) begin n_fail++;
        $display("FAIL rand%0d_count: got %0d accesses expected %0d", t, acc_q.size(), exp_na); end
      else for (int unsigned i = 0; i < exp_na; i++) begin
        if (split) e = '{we: we, sz: 2'b00, a: a + i, d: we ? {24'h0, d[8 * i +: 8]} : 32'h0};
        else e = '{we: we, sz: f3[1:0], a: a, d: we ? (n == 4 ? d : d & ((32'd1 << (8 * n)) - 32'd1)) : 32'h0};
        n_checks++; if (acc_q[i] !== e) begin n_fail++;
          $display("FAIL rand%0d_access%0d: got %h expected %h", t, i, acc_q[i], e); end
      end
      if (we && !exp_f) ref_store(f3, a, d);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 8'h40; i <= 8'h44; i++) begin mem[i] = 8'hEE; ref_mem[i] = 8'hEE; end
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h44332211;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_funct3 = 3'b010; req_addr = 32'h41;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL mid_reset_write_gated: got %b expected 0", mem_write); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", req_ready); end
    pulses = 0;
    repeat (6) begin @(negedge clk); if (resp_valid) pulses++; end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %0d pulses expected 0", pulses); end
`ifdef LSU_MISALIGN_SPLIT_EN
    ref_mem[8'h41] = 8'h11; ref_mem[8'h42] = 8'h22;
`endif
    for (int i = 8'h40; i <= 8'h44; i++) begin
      n_checks++; if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL mid_reset_mem[%h]: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++; if (both_rw != 0) begin n_fail++; $display("FAIL read_write_exclusive: got %0d overlapping cycles expected 0", both_rw); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
